// File: rtl/sw_debounce.sv
// Switch conditioner: 2-flop synchroniser, shared sample tick, per-bit debounce and change strobes.
// Optional macro SW_DEBOUNCE_EDGE_EN builds the oRise/oFall direction strobes.
module sw_debounce #(
    parameter int unsigned N            = 18,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 10
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic [N-1:0] iSW,
    output logic [N-1:0] oSW,
    output logic [N-1:0] oChanged,
    output logic         oAny,
    output logic [N-1:0] oRise,
    output logic [N-1:0] oFall
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [PW-1:0] presc;
    logic          tick;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  mismatch;
    logic [N-1:0]  flip;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= iSW;
            s2 <= s1;
        end
    end

    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        mismatch = s2 ^ oSW;
        flip     = '0;
        for (int i = 0; i < int'(N); i++) begin
            flip[i] = mismatch[i] & tick & (cnt[i] == CNT_LAST);
        end
    end

    // Any cycle where the synchronised level matches the output restarts qualification.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < int'(N); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (!mismatch[i] || flip[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oSW      <= '0;
            oChanged <= '0;
            oAny     <= 1'b0;
        end else begin
            oSW      <= oSW ^ flip;
            oChanged <= flip;
            oAny     <= |flip;
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oRise <= '0;
            oFall <= '0;
        end else begin
            oRise <= s2 & flip;
            oFall <= ~s2 & flip;
        end
    end
`else
    assign oRise = '0;
    assign oFall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: stimulus queues expected flips, a negedge monitor checks them.
// A second minimum-parameter instance checks the 3-edge latency directly.
module tb_sw_debounce;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sw = 4'b1010;
    logic [N-1:0] sw_o, chg, rise, fall;
    logic         any;

    logic [N-1:0] sw_m = '0;
    logic [N-1:0] sw_o_m, chg_m, rise_m, fall_m;
    logic         any_m;

    int cyc    = 0;
    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [N-1:0] sw;
        logic [N-1:0] chg;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        int           lo;
        int           hi;
    } exp_t;

    exp_t q[$];

    logic [N-1:0] prev_sw;
    logic         have_prev = 1'b0;

    sw_debounce #(.N(N), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
        .iCLK(clk), .iRST(rst), .iSW(sw), .oSW(sw_o), .oChanged(chg),
        .oAny(any), .oRise(rise), .oFall(fall)
    );

    sw_debounce #(.N(N), .TICK_DIV(1), .STABLE_TICKS(1)) dut_min (
        .iCLK(clk), .iRST(rst), .iSW(sw_m), .oSW(sw_o_m), .oChanged(chg_m),
        .oAny(any_m), .oRise(rise_m), .oFall(fall_m)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called at a negedge right after driving sw: first sampling edge is cyc+1.
    task automatic expect_flip(input logic [N-1:0] new_sw, input logic [N-1:0] flips);
        exp_t e;
        e.sw  = new_sw;
        e.chg = flips;
`ifdef SW_DEBOUNCE_EDGE_EN
        e.rise = flips & new_sw;
        e.fall = flips & ~new_sw;
`else
        e.rise = '0;
        e.fall = '0;
`endif
        e.lo = cyc + 11;
        e.hi = cyc + 14;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            fail(name, q.size(), 0);
            q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_osw"}, 32'(sw_o), 0);
        check({name, "_chg"}, 32'(chg), 0);
        check({name, "_any"}, 32'(any), 0);
        check({name, "_rise"}, 32'(rise), 0);
        check({name, "_fall"}, 32'(fall), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("any_is_or_changed", 32'(any), 32'(|chg));
            if (have_prev && sw_o !== prev_sw) begin
                check("osw_change_has_strobe", 32'(any), 1);
            end
            if (any) begin
                if (q.size() == 0) begin
                    fail("unexpected_strobe", int'(chg), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("flip_osw", 32'(sw_o), 32'(e.sw));
                    check("flip_changed", 32'(chg), 32'(e.chg));
                    check("flip_rise", 32'(rise), 32'(e.rise));
                    check("flip_fall", 32'(fall), 32'(e.fall));
                    if (cyc < e.lo || cyc > e.hi) fail("flip_time", cyc, e.lo);
                    else begin
                        checks++;
                        passed++;
                    end
                end
            end
        end
        prev_sw   = sw_o;
        have_prev = !rst;
    end

    initial begin
        // Reset with switches 1010 held steady.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        expect_flip(4'b1010, 4'b1010);
        repeat (5) @(negedge clk);
        check("osw_held_after_reset", 32'(sw_o), 0);
        drain("reset_release_flip");

        // Release both bits, then raise bit 0 alone.
        sw = 4'b0000;
        expect_flip(4'b0000, 4'b1010);
        drain("fall_1010");
        sw = 4'b0001;
        expect_flip(4'b0001, 4'b0001);
        drain("rise_bit0");

        // Bounce on bit 1: never stable for long enough to qualify.
        for (int k = 0; k < 40; k++) begin
            sw[1] = ((k / 3) % 2) == 0;
            @(negedge clk);
        end
        sw[1] = 1'b0;
        repeat (30) @(negedge clk);
        check("bounce_osw", 32'(sw_o), 32'h1);

        // Simultaneous flips of all bits.
        sw = 4'b0000;
        expect_flip(4'b0000, 4'b0001);
        drain("fall_bit0");
        sw = 4'b1111;
        expect_flip(4'b1111, 4'b1111);
        drain("all_rise");

        // Asynchronous reset clears outputs without waiting for an edge.
        sw  = 4'b0000;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("quiet_after_reset", 32'(sw_o), 0);

        // Reset mid-qualification discards partial progress.
        sw = 4'b0100;
        repeat (8) @(negedge clk);
        check("midqual_osw", 32'(sw_o), 0);
        rst = 1'b1;
        #1;
        check_all_zero("midqual_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_flip(4'b0100, 4'b0100);
        repeat (9) @(negedge clk);
        check("midqual_not_early", 32'(sw_o), 0);
        drain("midqual_flip");

        // Minimum configuration: flip on the 3rd edge after the first sampling edge.
        sw_m = 4'b0001;
        @(negedge clk);
        check("min_e1", 32'(sw_o_m), 0);
        @(negedge clk);
        check("min_e2", 32'(sw_o_m), 0);
        @(negedge clk);
        check("min_e3_osw", 32'(sw_o_m), 1);
        check("min_e3_chg", 32'(chg_m), 1);
        check("min_e3_any", 32'(any_m), 1);
        @(negedge clk);
        check("min_e4_chg", 32'(chg_m), 0);
        sw_m = 4'b0000;
        repeat (2) @(negedge clk);
        check("min_fall_e2", 32'(sw_o_m), 1);
        @(negedge clk);
        check("min_fall_e3", 32'(sw_o_m), 0);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("min_fall_strobe", 32'(fall_m), 1);
`else
        check("min_fall_strobe", 32'(fall_m), 0);
`endif

        repeat (5) @(negedge clk);
        if (q.size() != 0) fail("queue_empty_at_end", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
